// File: rtl/tcdm_wide_bank_if.sv
// Wide TCDM request/response bundle between the aggregator (master) and a bank (slave).
interface tcdm_wide_bank_if #(
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                    req_i;
    logic                    gnt_o;
    logic                    wen_i;
    logic [ADDR_WIDTH-1:0]   addr_i;
    logic [DATA_WIDTH-1:0]   data_i;
    logic [DATA_WIDTH/8-1:0] be_i;
    logic                    r_valid_o;
    logic                    r_ready_i;
    logic [DATA_WIDTH-1:0]   r_data_o;
    logic                    busy_o;

    modport master (
        output req_i, wen_i, addr_i, data_i, be_i, r_ready_i,
        input  gnt_o, r_valid_o, r_data_o, busy_o
    );

    modport slave (
        input  req_i, wen_i, addr_i, data_i, be_i, r_ready_i,
        output gnt_o, r_valid_o, r_data_o, busy_o
    );
endinterface

// File: rtl/tcdm_wide_bank.sv
// Wide single-port TCDM bank: byte-masked writes on handshake, reads buffered
// in an in-order response FIFO so r_ready backpressure never drops data.
module tcdm_wide_bank #(
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned NB_WORDS   = 256,
    parameter int unsigned RESP_DEPTH = 2
) (
    input logic             clk_i,
    input logic             resetn_i,
    tcdm_wide_bank_if.slave bus
);
    localparam int unsigned BE_W  = DATA_WIDTH / 8;
    localparam int unsigned OFF_W = $clog2(BE_W);
    localparam int unsigned IDX_W = $clog2(NB_WORDS);
    localparam int unsigned PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(RESP_DEPTH + 1);

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(RESP_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(RESP_DEPTH - 1);

    logic [DATA_WIDTH-1:0] r_mem  [NB_WORDS];
    logic [DATA_WIDTH-1:0] r_fifo [RESP_DEPTH];
    logic [PTR_W-1:0]      r_wptr;
    logic [PTR_W-1:0]      r_rptr;
    logic [CNT_W-1:0]      r_count;

    logic [IDX_W-1:0]      w_idx;
    logic                  w_valid;
    logic                  w_pop;
    logic                  w_not_full;
    logic                  w_gnt;
    logic                  w_wr;
    logic                  w_push;
    logic                  w_unused_addr;

    // Pointers wrap explicitly so RESP_DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        w_idx      = bus.addr_i[OFF_W +: IDX_W];
        w_valid    = (r_count != '0);
        w_pop      = w_valid & bus.r_ready_i;
        w_not_full = (r_count < DEPTH_C);
        w_gnt      = bus.req_i & (bus.wen_i | w_not_full | w_pop);
        // Grant stays combinational in reset, but the handshake is discarded.
        w_wr       = w_gnt &  bus.wen_i & resetn_i;
        w_push     = w_gnt & ~bus.wen_i & resetn_i;
    end

    // Offset and upper alias bits are intentionally ignored.
    assign w_unused_addr = ^bus.addr_i;

    assign bus.gnt_o     = w_gnt;
    assign bus.r_valid_o = w_valid;
    assign bus.busy_o    = w_valid;
    assign bus.r_data_o  = w_valid ? r_fifo[r_rptr] : '0;

    always_ff @(posedge clk_i) begin
        if (w_wr) begin
            for (int unsigned b = 0; b < BE_W; b++) begin
                if (bus.be_i[b]) begin
                    r_mem[w_idx][8*b +: 8] <= bus.data_i[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo[r_wptr] <= r_mem[w_idx];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= ptr_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= ptr_inc(r_rptr);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifndef SYNTHESIS
    logic                  r_dbg_held;
    logic [ADDR_WIDTH-1:0] r_dbg_addr;

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            r_dbg_held <= 1'b0;
            r_dbg_addr <= '0;
        end else begin
            assert (!$isunknown({bus.req_i, bus.wen_i}))
                else $error("tcdm_wide_bank: X on req_i/wen_i");
            if (r_dbg_held) begin
                assert (bus.req_i && !bus.wen_i && (bus.addr_i == r_dbg_addr))
                    else $error("tcdm_wide_bank: held read changed before grant");
            end
            r_dbg_held <= bus.req_i & ~bus.wen_i & ~w_gnt;
            r_dbg_addr <= bus.addr_i;
        end
    end
`endif
endmodule

// File: tb/tb_tcdm_wide_bank.sv
// Randomized scoreboard bench for tcdm_wide_bank: a byte-array memory model and
// an expected-response queue predict grants, response data and order.
module tb_tcdm_wide_bank;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    tcdm_wide_bank_if #(.DATA_WIDTH(128), .ADDR_WIDTH(32)) bus ();

    tcdm_wide_bank #(
        .DATA_WIDTH(128),
        .ADDR_WIDTH(32),
        .NB_WORDS  (256),
        .RESP_DEPTH(DEPTH)
    ) dut (
        .clk_i   (clk),
        .resetn_i(resetn),
        .bus     (bus.slave)
    );

    int   total = 0;
    int   bad   = 0;
    bit   started = 0;
    bit   done    = 0;
    bit   rdy_mode = 0;
    bit   rdy_val  = 0;
    int   drv_to_n = 0;

    logic [127:0] mm [256];
    logic [127:0] exp_q [$];

    function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // Ready driver: sole writer of r_ready_i.
    initial begin
        bus.r_ready_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.r_ready_i = rdy_mode ? 1'($urandom_range(0, 1)) : rdy_val;
        end
    end

    // Monitor / scoreboard.
    initial begin
        int seen_to = 0;
        while (!done) begin
            @(negedge clk);
            if (started) begin
                logic         ev;
                logic         pop;
                logic         eg;
                logic [31:0]  a;
                logic [7:0]   idx;
                ev = (exp_q.size() != 0);
                chk("r_valid", 128'(bus.r_valid_o), 128'(ev));
                chk("busy", 128'(bus.busy_o), 128'(ev));
                chk("r_data", bus.r_data_o, ev ? exp_q[0] : 128'd0);
                pop = ev && bus.r_ready_i;
                eg  = bus.req_i && (bus.wen_i || exp_q.size() < DEPTH || pop);
                chk("gnt", 128'(bus.gnt_o), 128'(eg));
                chk("req_timeout", 128'(drv_to_n), 128'(seen_to));
                seen_to = drv_to_n;
                if (pop) void'(exp_q.pop_front());
                a   = bus.addr_i;
                idx = a[11:4];
                if (!resetn) begin
                    exp_q.delete();
                end else if (eg) begin
                    if (bus.wen_i) begin
                        for (int b = 0; b < 16; b++)
                            if (bus.be_i[b]) mm[idx][8*b +: 8] = bus.data_i[8*b +: 8];
                    end else begin
                        exp_q.push_back(mm[idx]);
                    end
                end
            end
        end
        chk("drained", 128'(exp_q.size()), 128'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic issue(input bit w, input logic [31:0] a, input logic [127:0] d,
                         input logic [15:0] b, input bit release_rdy);
        int waited = 0;
        @(posedge clk);
        #1;
        bus.req_i  = 1'b1;
        bus.wen_i  = w;
        bus.addr_i = a;
        bus.data_i = d;
        bus.be_i   = b;
        forever begin
            @(negedge clk);
            if (bus.gnt_o) break;
            waited++;
            if (release_rdy && waited == 2) rdy_val = 1'b1;
            if (waited >= 64) begin
                drv_to_n++;
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        @(posedge clk);
        #1;
        bus.req_i = 1'b0;
        bus.wen_i = 1'b0;
        repeat (n - 1) @(posedge clk);
    endtask

    task automatic reset_pulse();
        @(posedge clk);
        #1;
        resetn    = 1'b0;
        bus.req_i = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        resetn     = 1'b0;
        bus.req_i  = 1'b0;
        bus.wen_i  = 1'b0;
        bus.addr_i = '0;
        bus.data_i = '0;
        bus.be_i   = '0;
        repeat (3) @(posedge clk);
        #1;
        resetn  = 1'b1;
        started = 1'b1;

        // Fill every word so later reads have defined contents.
        rdy_val = 1'b1;
        for (int i = 0; i < 256; i++) issue(1'b1, 32'(i) << 4, rnd128(), 16'hFFFF, 1'b0);
        idle(2);

        // Write / read-back, then partial byte-enable write.
        issue(1'b1, 32'h10, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677, 16'hFFFF, 1'b0);
        issue(1'b0, 32'h10, '0, '0, 1'b0);
        idle(2);
        issue(1'b1, 32'h10, '1, 16'h000F, 1'b0);
        issue(1'b0, 32'h10, '0, '0, 1'b0);
        idle(2);

        // Full FIFO backpressure: third read held until a pop frees a slot.
        rdy_val = 1'b0;
        issue(1'b0, 32'h10, '0, '0, 1'b0);
        issue(1'b0, 32'h20, '0, '0, 1'b0);
        issue(1'b0, 32'h30, '0, '0, 1'b1);
        idle(6);

        // Streaming reads.
        rdy_val = 1'b1;
        idle(2);
        for (int i = 0; i < 16; i++) issue(1'b0, $urandom, '0, '0, 1'b0);
        idle(3);

        // Aliasing, then a no-op zero byte-enable write.
        issue(1'b1, 32'h0000_0000, 128'hDEAD_BEEF_CAFE_F00D_1234_5678_9ABC_DEF0, 16'hFFFF, 1'b0);
        issue(1'b0, 32'h0000_1000, '0, '0, 1'b0);
        issue(1'b1, 32'h0000_0000, '1, 16'h0000, 1'b0);
        issue(1'b0, 32'h0000_0008, '0, '0, 1'b0);
        idle(3);

        // Reset with responses buffered.
        rdy_val = 1'b0;
        issue(1'b0, 32'h10, '0, '0, 1'b0);
        issue(1'b0, 32'h20, '0, '0, 1'b0);
        idle(3);
        reset_pulse();
        idle(3);
        rdy_val = 1'b1;
        issue(1'b0, 32'h10, '0, '0, 1'b0);
        issue(1'b0, 32'h0, '0, '0, 1'b0);
        idle(3);

        // Random mixed traffic with random backpressure.
        rdy_mode = 1'b1;
        for (int i = 0; i < 400; i++) begin
            logic [15:0] be;
            case ($urandom_range(0, 3))
                0:       be = 16'h0000;
                1:       be = 16'hFFFF;
                default: be = 16'($urandom);
            endcase
            issue(1'($urandom_range(0, 1)), $urandom, rnd128(), be, 1'b0);
            if ($urandom_range(0, 4) == 0) idle(1 + $urandom_range(0, 2));
        end

        rdy_mode = 1'b0;
        rdy_val  = 1'b1;
        idle(8);
        done = 1'b1;
    end
endmodule
